// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_pkg
// Description : Shared state encoding, IDLE drive values and phase-counter
//               width for the ram_loader write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

    // Width of the single phase down-counter (holds up to 15)
    localparam int c_CNT_W = 4;

    // Sequencer states; ST_VERIFY is only reached when RAM_LOADER_VERIFY_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RECOV  = 3'd4,
        ST_VERIFY = 3'd5
    } state_t;

    // Values presented to the RAM controller while idle
    localparam logic       c_IDLE_IE    = 1'b1;
    localparam logic       c_IDLE_MODE  = 1'b0;
    localparam logic       c_IDLE_FLUSH = 1'b1;
    localparam logic [7:0] c_IDLE_UI    = 8'h00;

endpackage : ram_loader_pkg
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Sequences one address/data entry into a RAM controller:
//               address setup, data setup, write strobe, recovery and an
//               optional readback verify. All outputs are registered.
//               Optional feature macro: RAM_LOADER_VERIFY_EN (readback verify).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int WR_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       req,
    output logic       ack,
    input  logic [7:0] addrIn,
    input  logic [7:0] dataIn,
    output logic       mode,
    output logic       flush,
    output logic       IE,
    output logic [7:0] userInput,
    input  logic [7:0] dataFromRAM,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Counter load values: a phase of N cycles loads N-1 and leaves at 0
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LD    = c_CNT_W'(WR_CYCLES - 1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_addr;
    logic [7:0]           r_data;
    logic                 r_ack;
    logic                 r_mode;
    logic                 r_flush;
    logic                 r_ie;
    logic [7:0]           r_ui;
    logic                 r_busy;
    logic                 r_done;

`ifdef RAM_LOADER_VERIFY_EN
    localparam logic [c_CNT_W-1:0] c_VERIFY_LD = c_CNT_W'(SETUP_CYCLES);
    logic                 r_error;
`else
    logic                 w_unused_ram;
    assign w_unused_ram = ^dataFromRAM;
`endif

    // Phase sequencer: next-state, counter and every output registered together
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
            r_ack   <= 1'b1;
            r_mode  <= c_IDLE_MODE;
            r_flush <= c_IDLE_FLUSH;
            r_ie    <= c_IDLE_IE;
            r_ui    <= c_IDLE_UI;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
            r_error <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req && r_ack) begin
                        r_addr  <= addrIn;
                        r_data  <= dataIn;
                        r_state <= ST_ADDR;
                        r_cnt   <= c_SETUP_LD;
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ie    <= 1'b0;
                        r_mode  <= 1'b0;
                        r_flush <= 1'b1;
                        r_ui    <= addrIn;
                    end
                end
                ST_ADDR: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_DATA;
                        r_cnt   <= c_SETUP_LD;
                        r_mode  <= 1'b1;
                        r_ui    <= r_data;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_WRITE;
                        r_cnt   <= c_WR_LD;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == '0) begin
                        // Recovery is a single cycle, so the counter loads zero
                        r_state <= ST_RECOV;
                        r_cnt   <= '0;
                        r_flush <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RECOV: begin
`ifdef RAM_LOADER_VERIFY_EN
                    // Re-present the address so the controller reads it back
                    r_state <= ST_VERIFY;
                    r_cnt   <= c_VERIFY_LD;
                    r_mode  <= 1'b0;
                    r_ui    <= r_addr;
`else
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ie    <= c_IDLE_IE;
                    r_mode  <= c_IDLE_MODE;
                    r_flush <= c_IDLE_FLUSH;
                    r_ui    <= c_IDLE_UI;
                    r_done  <= 1'b1;
`endif
                end
`ifdef RAM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (r_cnt == '0) begin
                        // Sticky: a good readback never clears an earlier mismatch
                        r_error <= r_error | (dataFromRAM != r_data);
                        r_state <= ST_IDLE;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ie    <= c_IDLE_IE;
                        r_mode  <= c_IDLE_MODE;
                        r_flush <= c_IDLE_FLUSH;
                        r_ui    <= c_IDLE_UI;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ie    <= c_IDLE_IE;
                    r_mode  <= c_IDLE_MODE;
                    r_flush <= c_IDLE_FLUSH;
                    r_ui    <= c_IDLE_UI;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign mode      = r_mode;
    assign flush     = r_flush;
    assign IE        = r_ie;
    assign userInput = r_ui;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef RAM_LOADER_VERIFY_EN
    assign error     = r_error;
`else
    assign error     = 1'b0;
`endif

endmodule : ram_loader
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Self-checking bench for ram_loader. Two instances (default
//               timing and SETUP=3/WR=4) each talk to a behavioural SRAM with
//               bit 0 of address 0x20 stuck at zero. Expected per-cycle
//               traces are derived from phase lengths.
//               Honours RAM_LOADER_VERIFY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
    localparam bit c_VERIFY = 1'b1;
`else
    localparam bit c_VERIFY = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] addrIn = 8'h00, dataIn = 8'h00;

    logic       ack0, mode0, flush0, ie0, busy0, done0, err0;
    logic       ack1, mode1, flush1, ie1, busy1, done1, err1;
    logic [7:0] ui0, ui1, dfr0, dfr1;

    always #5 CLK = ~CLK;

    ram_loader u_dut0 (
        .CLK(CLK), .CLR(CLR), .req(req0), .ack(ack0),
        .addrIn(addrIn), .dataIn(dataIn),
        .mode(mode0), .flush(flush0), .IE(ie0), .userInput(ui0),
        .dataFromRAM(dfr0), .busy(busy0), .done(done0), .error(err0)
    );

    ram_loader #(.SETUP_CYCLES(3), .WR_CYCLES(4)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .req(req1), .ack(ack1),
        .addrIn(addrIn), .dataIn(dataIn),
        .mode(mode1), .flush(flush1), .IE(ie1), .userInput(ui1),
        .dataFromRAM(dfr1), .busy(busy1), .done(done1), .error(err1)
    );

    // Behavioural SRAMs: address latched in address mode, written while strobe low
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ra0 = 8'h00, ra1 = 8'h00;

    always @(posedge CLK) begin
        if (!ie0 && !mode0) ra0 <= ui0;
        if (!flush0)        mem0[ra0] <= ui0;
        if (!ie1 && !mode1) ra1 <= ui1;
        if (!flush1)        mem1[ra1] <= ui1;
    end
    assign dfr0 = mem0[ra0] & ((ra0 == 8'h20) ? 8'hFE : 8'hFF);
    assign dfr1 = mem1[ra1] & ((ra1 == 8'h20) ? 8'hFE : 8'hFF);

    // Observation mux selecting the instance under test
    bit         sel = 1'b0;
    logic       o_ack, o_mode, o_flush, o_ie, o_busy, o_done, o_err;
    logic [7:0] o_ui;
    assign o_ack   = sel ? ack1   : ack0;
    assign o_mode  = sel ? mode1  : mode0;
    assign o_flush = sel ? flush1 : flush0;
    assign o_ie    = sel ? ie1    : ie0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_done  = sel ? done1  : done0;
    assign o_err   = sel ? err1   : err0;
    assign o_ui    = sel ? ui1    : ui0;

    int checks = 0;
    int errors = 0;
    bit exp_err [2];

    typedef struct packed {
        logic       mode;
        logic       flush;
        logic       ie;
        logic [7:0] ui;
        logic       ui_chk;
        logic       busy;
        logic       done;
        logic       ack;
    } exp_t;

    exp_t q_tr[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle outputs after acceptance, from phase lengths alone
    task automatic build_trace(input int s, input int w, input logic [7:0] a, input logic [7:0] d);
        q_tr.delete();
        for (int i = 0; i < s; i++) q_tr.push_back('{1'b0, 1'b1, 1'b0, a,     1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < s; i++) q_tr.push_back('{1'b1, 1'b1, 1'b0, d,     1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < w; i++) q_tr.push_back('{1'b1, 1'b0, 1'b0, d,     1'b1, 1'b1, 1'b0, 1'b0});
        q_tr.push_back(                             '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        if (c_VERIFY)
            for (int i = 0; i < s + 1; i++) q_tr.push_back('{1'b0, 1'b1, 1'b0, a, 1'b1, 1'b1, 1'b0, 1'b0});
        q_tr.push_back(                             '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic set_req(input logic v);
        if (sel) req1 = v; else req0 = v;
    endtask

    // Wait (bounded) for ack, then present an entry
    task automatic start_txn(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge CLK);
        while (!o_ack && n < 64) begin
            @(negedge CLK);
            n++;
        end
        chk("ack_wait", {7'b0, o_ack}, 8'h01);
        addrIn = a;
        dataIn = d;
        set_req(1'b1);
    endtask

    // Follow one accepted entry cycle by cycle against the expected trace
    task automatic follow_txn(input logic [7:0] a, input logic [7:0] d, input bit keep,
                              input logic [7:0] na, input logic [7:0] nd);
        int s = sel ? 3 : 1;
        int w = sel ? 4 : 2;
        int fl_cnt = 0;
        int mchg = 0;
        logic pmode;
        bit err_new = exp_err[sel] | (c_VERIFY && a == 8'h20 && d[0]);
        build_trace(s, w, a, d);
        @(posedge CLK);
        pmode = 1'b0;
        for (int k = 0; k < q_tr.size(); k++) begin
            @(negedge CLK);
            chk($sformatf("k%0d_mode", k),  {7'b0, o_mode},  {7'b0, q_tr[k].mode});
            chk($sformatf("k%0d_flush", k), {7'b0, o_flush}, {7'b0, q_tr[k].flush});
            chk($sformatf("k%0d_ie", k),    {7'b0, o_ie},    {7'b0, q_tr[k].ie});
            if (q_tr[k].ui_chk)
                chk($sformatf("k%0d_ui", k), o_ui, q_tr[k].ui);
            chk($sformatf("k%0d_busy", k),  {7'b0, o_busy},  {7'b0, q_tr[k].busy});
            chk($sformatf("k%0d_done", k),  {7'b0, o_done},  {7'b0, q_tr[k].done});
            chk($sformatf("k%0d_ack", k),   {7'b0, o_ack},   {7'b0, q_tr[k].ack});
            chk($sformatf("k%0d_error", k), {7'b0, o_err},
                {7'b0, (k == q_tr.size() - 1) ? err_new : exp_err[sel]});
            if (!o_flush) begin
                fl_cnt++;
                if (o_mode !== pmode) mchg++;
            end
            pmode = o_mode;
            if (k == 0) begin
                // Input changes after acceptance must not disturb the entry
                addrIn = 8'($urandom_range(0, 255));
                dataIn = 8'($urandom_range(0, 255));
                if (!keep) set_req(1'b0);
            end
            if (keep && k == q_tr.size() - 1) begin
                addrIn = na;
                dataIn = nd;
            end
        end
        exp_err[sel] = err_new;
        chk("flush_low_len", 8'(fl_cnt), 8'(w));
        chk("mode_chg_in_write", 8'(mchg), 8'h00);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] d);
        start_txn(a, d);
        follow_txn(a, d, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mode"},  {7'b0, o_mode},  8'h00);
        chk({tag, "_flush"}, {7'b0, o_flush}, 8'h01);
        chk({tag, "_ie"},    {7'b0, o_ie},    8'h01);
        chk({tag, "_ui"},    o_ui,            8'h00);
        chk({tag, "_busy"},  {7'b0, o_busy},  8'h00);
        chk({tag, "_done"},  {7'b0, o_done},  8'h00);
        chk({tag, "_ack"},   {7'b0, o_ack},   8'h01);
        chk({tag, "_error"}, {7'b0, o_err},   8'h00);
    endtask

    initial begin : stim
        int done_seen;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;

        // Reset state of both instances
        repeat (3) @(negedge CLK);
        sel = 1'b0; chk_idle("rst0");
        sel = 1'b1; chk_idle("rst1");
        CLR = 1'b1;

        // Directed default entry
        sel = 1'b0;
        run_txn(8'h0F, 8'hA5);

        // Back-to-back entries with req held high
        start_txn(8'h00, 8'h11);
        follow_txn(8'h00, 8'h11, 1'b1, 8'h01, 8'h22);
        follow_txn(8'h01, 8'h22, 1'b0, 8'h00, 8'h00);

        // Stuck bit at 0x20, then a good write: error must stay sticky
        run_txn(8'h20, 8'hFF);
        run_txn(8'h21, 8'h5A);

        // Randomised entries on both instances
        for (int i = 0; i < 4; i++) begin
            sel = 1'b0;
            run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            sel = 1'b1;
            run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Long setup/write timing
        sel = 1'b1;
        run_txn(8'h3C, 8'hC3);

        // Reset during the second write cycle drops the entry
        sel = 1'b0;
        start_txn(8'h44, 8'h99);
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (k == 0) set_req(1'b0);
        end
        chk("abort_in_write", {7'b0, o_flush}, 8'h00);
        CLR = 1'b0;
        @(negedge CLK);
        chk_idle("abort");
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
        CLR = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (o_done) done_seen++;
        end
        chk("abort_no_done", 8'(done_seen), 8'h00);

        // Normal operation resumes after the abort
        run_txn(8'h55, 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_loader
`default_nettype wire
